hilo_writeback: RTL
===================

HILO_WRITEBACK -- requirements
Module: hilo_writeback

Interface
REQ-001 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: stall_wb_now  in  1  hold all WB-stage state; flush_wb  in  1  load a bubble into WB.
REQ-004 SHALL have ports: wr_reg_en_mem, link_mem, hi_wr_en_mem, lo_wr_en_mem  in  1 each  MEM-stage controls.
REQ-005 SHALL have ports: mem_to_reg_mem  in  2  result select; wr_reg_addr_mem  in  5  GPR destination.
REQ-006 SHALL have ports: alu_to_mem, mem_rd_data_mem, hi_lo_mem, PC4_mem, res_hi_mem, res_lo_mem  in  32 each  MEM-stage data.
REQ-007 SHALL have ports: mfhi_ex, mflo_ex  in  1 each  Execute-stage HI/LO read requests.
REQ-008 SHALL have ports: hi_ex, lo_ex  out  32 each  HI/LO values returned to Execute.
REQ-009 SHALL have ports: wr_reg_en_wb  out  1; wr_reg_addr_wb  out  5; wr_data_wb  out  32  GPR write port.
REQ-010 SHALL have ports: hi_wr_en_wb, lo_wr_en_wb  out  1; res_hi_wb, res_lo_wb  out  32  WB-stage HI/LO write.
REQ-011 SHALL have ports: hilo_hazard  out  1  Execute stall request; retire_cnt  out  32  retired-instruction count.

Function
REQ-012 SHALL capture all *_mem inputs into WB registers on each rising clk edge, one-cycle latency.
REQ-013 SHALL hold every WB register and HI/LO when stall_wb_now=1; flush_wb=1 with stall_wb_now=0 SHALL load a bubble (all enables 0, data 0).
REQ-014 SHALL give stall_wb_now priority over flush_wb in the same cycle.
REQ-015 SHALL drive wr_data_wb combinationally from mem_to_reg_wb: 00 alu, 01 mem_rd_data, 10 hi_lo, 11 PC4.
REQ-016 SHALL, when link_wb=1, force wr_reg_addr_wb=31 and wr_data_wb=PC4_wb+4 (mod 2^32), overriding the select.
REQ-017 SHALL write HI on a rising edge when hi_wr_en_wb=1 and not stalled; LO likewise, independently; both SHALL update when both are set.
REQ-018 SHALL, with bypass, drive hi_ex by priority: res_hi_mem if hi_wr_en_mem, else res_hi_wb if hi_wr_en_wb, else the HI register; lo_ex likewise.
REQ-019 SHALL drive hilo_hazard=0 when bypass is compiled in.
REQ-020 SHALL increment retire_cnt by 1 per unstalled edge whose WB slot holds a non-bubble (any WB enable set), wrapping 0xFFFFFFFF->0.

Reset
REQ-021 SHALL, on reset=0, asynchronously clear all WB registers, HI, LO and retire_cnt to 0; all outputs SHALL read 0.
REQ-022 SHALL hold reset state while reset=0 regardless of stall/flush, and resume capture on the first rising edge after release.
REQ-023 SHALL discard an in-flight WB instruction on mid-operation reset; no HI/LO or GPR write occurs.

Configuration
REQ-024 SHALL use macro HILO_BYPASS_EN: defined -> REQ-018/019 forwarding; undefined -> hi_ex/lo_ex return registered HI/LO only.
REQ-025 SHALL, without HILO_BYPASS_EN, assert hilo_hazard = (mfhi_ex & (hi_wr_en_mem|hi_wr_en_wb)) | (mflo_ex & (lo_wr_en_mem|lo_wr_en_wb)).

Structure
REQ-026 SHALL place the mem_to_reg encoding enum (WB_SEL_ALU, WB_SEL_MEM, WB_SEL_HILO, WB_SEL_PC) and LINK_REG=5'd31 in a shared package.
REQ-027 SHALL implement HI/LO storage plus read bypass as sub-module hilo_regs.

Verification
REQ-028 SHALL cover: MEM mem_to_reg=01, mem_rd_data=0xDEADBEEF, addr 7 -> next cycle wr_data_wb=0xDEADBEEF, addr 7, en 1.
REQ-029 SHALL cover: link_mem=1, PC4=0x00400010 -> wr_reg_addr_wb=31, wr_data_wb=0x00400014.
REQ-030 SHALL cover: hi/lo_wr_en both 1, res_hi=0x1, res_lo=0x2 -> after WB edge HI=0x1 and LO=0x2 simultaneously.
REQ-031 SHALL cover (bypass): MEM hi_wr_en=1, res_hi=0xAAAA0000, WB hi_wr_en=1, res_hi=0x5555, mfhi_ex=1 -> hi_ex=0xAAAA0000; without macro hilo_hazard=1, hi_ex=old HI.
REQ-032 SHALL cover: stall_wb_now=1 and flush_wb=1 for 2 cycles -> WB outputs, HI/LO, retire_cnt unchanged.
REQ-033 SHALL cover: reset=0 asserted mid-cycle with WB hi_wr_en=1 -> HI, LO, retire_cnt=0 immediately, no write after release.

Source files
------------

// File: rtl/hilo_writeback_pkg.sv
// Shared types and constants for the HI/LO writeback slice.
// Used by hilo_writeback, hilo_writeback_if and hilo_regs.
package hilo_writeback_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] LINK_REG = 5'd31;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_MEM  = 2'b01,
    WB_SEL_HILO = 2'b10,
    WB_SEL_PC   = 2'b11
  } wb_sel_e;

  // Everything the WB stage keeps about one instruction
  typedef struct packed {
    logic              wr_reg_en;
    logic              link;
    logic              hi_wr_en;
    logic              lo_wr_en;
    wb_sel_e           sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem_rd;
    logic [DATA_W-1:0] hi_lo;
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] res_hi;
    logic [DATA_W-1:0] res_lo;
  } wb_stage_t;

endpackage

// File: rtl/hilo_writeback_if.sv
// MEM-to-WB bus: the MEM stage drives it (master), writeback consumes it (slave).
interface hilo_writeback_if;
  import hilo_writeback_pkg::*;

  logic              wr_reg_en_mem;
  logic              link_mem;
  logic              hi_wr_en_mem;
  logic              lo_wr_en_mem;
  logic [1:0]        mem_to_reg_mem;
  logic [ADDR_W-1:0] wr_reg_addr_mem;
  logic [DATA_W-1:0] alu_to_mem;
  logic [DATA_W-1:0] mem_rd_data_mem;
  logic [DATA_W-1:0] hi_lo_mem;
  logic [DATA_W-1:0] PC4_mem;
  logic [DATA_W-1:0] res_hi_mem;
  logic [DATA_W-1:0] res_lo_mem;

  modport master (
    output wr_reg_en_mem, link_mem, hi_wr_en_mem, lo_wr_en_mem, mem_to_reg_mem,
           wr_reg_addr_mem, alu_to_mem, mem_rd_data_mem, hi_lo_mem, PC4_mem,
           res_hi_mem, res_lo_mem
  );

  modport slave (
    input  wr_reg_en_mem, link_mem, hi_wr_en_mem, lo_wr_en_mem, mem_to_reg_mem,
           wr_reg_addr_mem, alu_to_mem, mem_rd_data_mem, hi_lo_mem, PC4_mem,
           res_hi_mem, res_lo_mem
  );

endinterface

// File: rtl/hilo_writeback_hilo_regs.sv
// HI/LO architectural registers with the Execute-stage read path.
// HILO_BYPASS_EN: forward in-flight MEM/WB results; otherwise raise hilo_hazard.
module hilo_regs
  import hilo_writeback_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_wb_now,
  input  logic              hi_wr_en_wb,
  input  logic              lo_wr_en_wb,
  input  logic [DATA_W-1:0] res_hi_wb,
  input  logic [DATA_W-1:0] res_lo_wb,
  input  logic              hi_wr_en_mem,
  input  logic              lo_wr_en_mem,
`ifdef HILO_BYPASS_EN
  input  logic [DATA_W-1:0] res_hi_mem,
  input  logic [DATA_W-1:0] res_lo_mem,
`else
  input  logic              mfhi_ex,
  input  logic              mflo_ex,
`endif
  output logic [DATA_W-1:0] hi_ex,
  output logic [DATA_W-1:0] lo_ex,
  output logic              hilo_hazard
);

  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  // HI and LO commit independently; a stalled WB slot must not commit yet
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (!stall_wb_now) begin
      if (hi_wr_en_wb) hi_q <= res_hi_wb;
      if (lo_wr_en_wb) lo_q <= res_lo_wb;
    end
  end

`ifdef HILO_BYPASS_EN
  // Youngest writer wins: MEM beats WB beats the committed register
  always_comb begin
    hi_ex = hi_q;
    lo_ex = lo_q;
    if (hi_wr_en_mem)     hi_ex = res_hi_mem;
    else if (hi_wr_en_wb) hi_ex = res_hi_wb;
    if (lo_wr_en_mem)     lo_ex = res_lo_mem;
    else if (lo_wr_en_wb) lo_ex = res_lo_wb;
  end

  assign hilo_hazard = 1'b0;
`else
  assign hi_ex = hi_q;
  assign lo_ex = lo_q;

  assign hilo_hazard = (mfhi_ex & (hi_wr_en_mem | hi_wr_en_wb)) |
                       (mflo_ex & (lo_wr_en_mem | lo_wr_en_wb));
`endif

endmodule

// File: rtl/hilo_writeback.sv
// Writeback stage: MEM->WB pipeline register, GPR result mux with link override,
// HI/LO registers and retire counter. Optional macro HILO_BYPASS_EN enables HI/LO forwarding.
module hilo_writeback
  import hilo_writeback_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall_wb_now,
  input  logic                 flush_wb,
  hilo_writeback_if.slave      mem_bus,
  input  logic                 mfhi_ex,
  input  logic                 mflo_ex,
  output logic [DATA_W-1:0]    hi_ex,
  output logic [DATA_W-1:0]    lo_ex,
  output logic                 wr_reg_en_wb,
  output logic [ADDR_W-1:0]    wr_reg_addr_wb,
  output logic [DATA_W-1:0]    wr_data_wb,
  output logic                 hi_wr_en_wb,
  output logic                 lo_wr_en_wb,
  output logic [DATA_W-1:0]    res_hi_wb,
  output logic [DATA_W-1:0]    res_lo_wb,
  output logic                 hilo_hazard,
  output logic [DATA_W-1:0]    retire_cnt
);

  function automatic logic [DATA_W-1:0] link_data(input logic [DATA_W-1:0] pc4);
    return pc4 + DATA_W'(4);
  endfunction

  wb_stage_t mem_p0;
  wb_stage_t wb_p1;
  logic      vld_p1;

  assign mem_p0 = '{
    wr_reg_en: mem_bus.wr_reg_en_mem,
    link:      mem_bus.link_mem,
    hi_wr_en:  mem_bus.hi_wr_en_mem,
    lo_wr_en:  mem_bus.lo_wr_en_mem,
    sel:       wb_sel_e'(mem_bus.mem_to_reg_mem),
    addr:      mem_bus.wr_reg_addr_mem,
    alu:       mem_bus.alu_to_mem,
    mem_rd:    mem_bus.mem_rd_data_mem,
    hi_lo:     mem_bus.hi_lo_mem,
    pc4:       mem_bus.PC4_mem,
    res_hi:    mem_bus.res_hi_mem,
    res_lo:    mem_bus.res_lo_mem
  };

  // ---- MEM -> WB boundary ----
  // Stall outranks flush; the slot leaving WB on an unstalled edge is what retires
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_p1      <= '0;
      retire_cnt <= '0;
    end else if (!stall_wb_now) begin
      wb_p1 <= flush_wb ? '0 : mem_p0;
      if (vld_p1) retire_cnt <= retire_cnt + DATA_W'(1);
    end
  end

  assign vld_p1 = wb_p1.wr_reg_en | wb_p1.hi_wr_en | wb_p1.lo_wr_en;

  // ---- WB outputs ----
  always_comb begin
    wr_data_wb = wb_p1.alu;
    case (wb_p1.sel)
      WB_SEL_ALU:  wr_data_wb = wb_p1.alu;
      WB_SEL_MEM:  wr_data_wb = wb_p1.mem_rd;
      WB_SEL_HILO: wr_data_wb = wb_p1.hi_lo;
      WB_SEL_PC:   wr_data_wb = wb_p1.pc4;
      default:     wr_data_wb = wb_p1.alu;
    endcase
    wr_reg_addr_wb = wb_p1.addr;
    if (wb_p1.link) begin
      wr_data_wb     = link_data(wb_p1.pc4);
      wr_reg_addr_wb = LINK_REG;
    end
  end

  assign wr_reg_en_wb = wb_p1.wr_reg_en;
  assign hi_wr_en_wb  = wb_p1.hi_wr_en;
  assign lo_wr_en_wb  = wb_p1.lo_wr_en;
  assign res_hi_wb    = wb_p1.res_hi;
  assign res_lo_wb    = wb_p1.res_lo;

  hilo_regs u_hilo_regs (
    .clk          (clk),
    .reset        (reset),
    .stall_wb_now (stall_wb_now),
    .hi_wr_en_wb  (wb_p1.hi_wr_en),
    .lo_wr_en_wb  (wb_p1.lo_wr_en),
    .res_hi_wb    (wb_p1.res_hi),
    .res_lo_wb    (wb_p1.res_lo),
    .hi_wr_en_mem (mem_bus.hi_wr_en_mem),
    .lo_wr_en_mem (mem_bus.lo_wr_en_mem),
`ifdef HILO_BYPASS_EN
    .res_hi_mem   (mem_bus.res_hi_mem),
    .res_lo_mem   (mem_bus.res_lo_mem),
`else
    .mfhi_ex      (mfhi_ex),
    .mflo_ex      (mflo_ex),
`endif
    .hi_ex        (hi_ex),
    .lo_ex        (lo_ex),
    .hilo_hazard  (hilo_hazard)
  );

endmodule
